// File: rtl/word_unpacker.sv
// word_unpacker
//   Fetches words from a file ROM one request at a time and streams each word
//   to a byte-wide valid/ready consumer, most significant byte first.
//
//   Parameter
//     WORD_BYTES  bytes per ROM word (default 8)
//   Ports
//     clk         rising-edge clock
//     rst         asynchronous active-high reset
//     start       one-cycle pulse: begin streaming a file (accepted in IDLE/DONE)
//     cs          one-cycle word request to the ROM
//     valid       ROM word strobe (only honoured while waiting for a word)
//     data_out    ROM word, 8*WORD_BYTES bits
//     eof         marks the file's final word, qualified by valid
//     byte_data   current byte to the downstream engine
//     byte_valid  byte_data is valid
//     byte_ready  downstream accepts the byte when high together with byte_valid
//     byte_last   final byte of the file
//     done        high after the last byte transfers, until the next start
//     byte_count  (only with WORD_UNPACKER_BYTE_COUNT_EN) running transfer count
//
//   Optional feature macro: WORD_UNPACKER_BYTE_COUNT_EN
module word_unpacker #(
  parameter int unsigned WORD_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    cs,
  input  logic                    valid,
  input  logic [8*WORD_BYTES-1:0] data_out,
  input  logic                    eof,
  output logic [7:0]              byte_data,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    byte_last,
  output logic                    done
`ifdef WORD_UNPACKER_BYTE_COUNT_EN
  ,
  output logic [31:0]             byte_count
`endif
);

  localparam int unsigned IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [8*WORD_BYTES-1:0] buffer;
  logic [IDX_W-1:0]        index;
  logic                    last_word;

  logic                    accept_start;
  logic                    load;
  logic                    xfer;
  logic [7:0]              sel_byte;

  assign accept_start = start && ((state == IDLE) || (state == DONE));
  assign load         = (state == WAIT) && valid;
  assign xfer         = (state == DRAIN) && byte_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (valid) state_nxt = DRAIN;
      DRAIN:   if (byte_ready && (index == LAST_IDX))
                 state_nxt = last_word ? DONE : REQ;
      DONE:    if (start) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      buffer    <= '0;
      index     <= '0;
      last_word <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept_start) begin
        buffer    <= '0;
        index     <= '0;
        last_word <= 1'b0;
      end else if (load) begin
        buffer    <= data_out;
        last_word <= eof;
        index     <= '0;
      end else if (xfer && (index != LAST_IDX)) begin
        index <= index + 1'b1;
      end
    end
  end

  // Byte 0 sits in the top byte lane of the buffer.
  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (index == IDX_W'(i))
        sel_byte = buffer[8*(WORD_BYTES-1-i) +: 8];
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign cs         = (state == REQ);
  assign byte_valid = (state == DRAIN);
  assign byte_data  = (state == DRAIN) ? sel_byte : 8'h00;
  assign byte_last  = (state == DRAIN) && last_word && (index == LAST_IDX);
  assign done       = (state == DONE);

`ifdef WORD_UNPACKER_BYTE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      byte_count <= '0;
    else if (accept_start)
      byte_count <= '0;
    else if (xfer)
      byte_count <= byte_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_word_unpacker.sv
// Self-checking bench for word_unpacker (WORD_BYTES = 8).
// A table of file scenarios drives a one-cycle-latency ROM and a byte
// consumer; each received byte is compared with the expected stream.
module tb_word_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cs;
  logic        valid;
  logic [63:0] data_out;
  logic        eof;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_last;
  logic        done;
`ifdef WORD_UNPACKER_BYTE_COUNT_EN
  logic [31:0] byte_count;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  word_unpacker #(.WORD_BYTES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cs         (cs),
    .valid      (valid),
    .data_out   (data_out),
    .eof        (eof),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last),
    .done       (done)
`ifdef WORD_UNPACKER_BYTE_COUNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] w0;
    logic [63:0] w1;
    int unsigned nwords;
    int unsigned toggle;     // 1: byte_ready alternates every cycle
    int unsigned spur;       // 1: stray valid in DRAIN and stray start in WAIT
    int unsigned abort_at;   // nonzero: assert rst while this byte index is shown
    logic [7:0]  last_byte;
    int unsigned exp_cycles; // cycles from REQ to DONE, 0 = not checked
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0]  exp_b [16];
    int unsigned total;
    int unsigned got;
    int unsigned wi;
    int unsigned cycles;
    int unsigned cs_cnt;
    logic        pend;
    logic        held;
    logic        tog;
    logic [7:0]  prev;
    logic [63:0] w;

    for (int i = 0; i < 8; i++) begin
      exp_b[i]   = v.w0[63-8*i -: 8];
      exp_b[i+8] = v.w1[63-8*i -: 8];
    end
    total  = 8 * v.nwords;
    got    = 0;
    wi     = 0;
    cycles = 0;
    cs_cnt = 0;
    pend   = 1'b0;
    held   = 1'b0;
    tog    = 1'b1;
    prev   = 8'h00;

    start = 1'b1;
    step();
    start = 1'b0;
`ifdef WORD_UNPACKER_BYTE_COUNT_EN
    chk("byte_count_after_start", {32'd0, byte_count}, 64'd0);
`endif

    while (!done && cycles < 200) begin
      if (cs) cs_cnt++;

      // Drive this cycle's inputs (sampled at the coming edge).
      valid = 1'b0;
      eof   = 1'b0;
      start = (v.spur != 0) && pend;
      if (pend) begin
        w        = (wi == 0) ? v.w0 : v.w1;
        valid    = 1'b1;
        data_out = w;
        eof      = (wi == v.nwords - 1);
        wi++;
      end else if (v.spur != 0 && byte_valid && got == 2) begin
        valid    = 1'b1;
        data_out = '1;
        eof      = 1'b1;
      end
      pend       = cs;
      byte_ready = (v.toggle != 0) ? tog : 1'b1;
      tog        = ~tog;

      if (byte_valid) begin
        if (v.abort_at != 0 && got == v.abort_at) begin
          #2 rst = 1'b1;
          #1;
          chk("rst_cs",         {63'd0, cs},         64'd0);
          chk("rst_byte_valid", {63'd0, byte_valid}, 64'd0);
          chk("rst_byte_last",  {63'd0, byte_last},  64'd0);
          chk("rst_done",       {63'd0, done},       64'd0);
          chk("rst_byte_data",  {56'd0, byte_data},  64'd0);
          valid = 1'b0;
          start = 1'b0;
          step();
          rst = 1'b0;
          for (int k = 0; k < 4; k++) begin
            step();
            chk("idle_after_rst", {62'd0, cs, byte_valid}, 64'd0);
          end
          return;
        end
        if (held) chk("hold_stable", {56'd0, byte_data}, {56'd0, prev});
        if (got < total) begin
          chk("byte_data", {56'd0, byte_data}, {56'd0, exp_b[got]});
          chk("byte_last", {63'd0, byte_last}, {63'd0, (got == total - 1)});
        end else begin
          chk("extra_byte", {32'd0, got}, {32'd0, total - 1});
        end
        if (byte_ready && got == total - 1)
          chk("final_byte", {56'd0, byte_data}, {56'd0, v.last_byte});
        held = !byte_ready;
        prev = byte_data;
        if (byte_ready) got++;
      end else begin
        held = 1'b0;
      end

      step();
      cycles++;
    end
    valid      = 1'b0;
    start      = 1'b0;
    byte_ready = 1'b1;

    chk("done_reached", {63'd0, done}, 64'd1);
    chk("byte_total",   {32'd0, got},    {32'd0, total});
    chk("cs_pulses",    {32'd0, cs_cnt}, {32'd0, v.nwords});
    if (v.exp_cycles != 0)
      chk("throughput", {32'd0, cycles}, {32'd0, v.exp_cycles});
`ifdef WORD_UNPACKER_BYTE_COUNT_EN
    chk("byte_count_at_done", {32'd0, byte_count}, {32'd0, total});
`endif
    step();
    chk("done_held", {62'd0, done, byte_valid}, 64'd2);
  endtask

  vec_t vt [6];

  initial begin
    vt[0] = '{w0: 64'h0011223344556677, w1: 64'h0, nwords: 1, toggle: 0, spur: 0,
              abort_at: 0, last_byte: 8'h77, exp_cycles: 10};
    vt[1] = '{w0: 64'h0102030405060708, w1: 64'h1112131415161718, nwords: 2, toggle: 0,
              spur: 0, abort_at: 0, last_byte: 8'h18, exp_cycles: 20};
    vt[2] = '{w0: 64'h0102030405060708, w1: 64'h1112131415161718, nwords: 2, toggle: 1,
              spur: 0, abort_at: 0, last_byte: 8'h18, exp_cycles: 0};
    vt[3] = '{w0: 64'hA0A1A2A3A4A5A6A7, w1: 64'hB0B1B2B3B4B5B6B7, nwords: 2, toggle: 0,
              spur: 0, abort_at: 3, last_byte: 8'hB7, exp_cycles: 0};
    vt[4] = '{w0: 64'hA0A1A2A3A4A5A6A7, w1: 64'h0, nwords: 1, toggle: 0, spur: 0,
              abort_at: 0, last_byte: 8'hA7, exp_cycles: 10};
    vt[5] = '{w0: 64'h0102030405060708, w1: 64'h1112131415161718, nwords: 2, toggle: 0,
              spur: 1, abort_at: 0, last_byte: 8'h18, exp_cycles: 20};

    rst        = 1'b1;
    start      = 1'b0;
    valid      = 1'b0;
    data_out   = '0;
    eof        = 1'b0;
    byte_ready = 1'b1;
    #3;
    chk("reset_outputs", {52'd0, cs, byte_valid, byte_last, done, byte_data},
        64'd0);
`ifdef WORD_UNPACKER_BYTE_COUNT_EN
    chk("reset_byte_count", {32'd0, byte_count}, 64'd0);
`endif
    step();
    step();
    rst = 1'b0;

    // Inputs other than start are ignored in IDLE.
    valid    = 1'b1;
    data_out = '1;
    eof      = 1'b1;
    step();
    step();
    valid = 1'b0;
    eof   = 1'b0;
    chk("idle_ignores_valid", {60'd0, cs, byte_valid, byte_last, done}, 64'd0);

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/word_unpacker.md
WORD_UNPACKER -- requirements
Module: word_unpacker

Interface
REQ-001 The block SHALL have parameter WORD_BYTES, default 8, meaning the number of bytes per source word.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a one-cycle pulse that begins streaming one file.
REQ-005 The block SHALL have port cs, output, 1 bit, a one-cycle word request to the file ROM.
REQ-006 The block SHALL have port valid, input, 1 bit, ROM word-valid strobe.
REQ-007 The block SHALL have port data_out, input, 8*WORD_BYTES bits, ROM word.
REQ-008 The block SHALL have port eof, input, 1 bit, high together with valid on the file's final word.
REQ-009 The block SHALL have port byte_data, output, 8 bits, the current byte to the downstream LZW engine.
REQ-010 The block SHALL have port byte_valid, output, 1 bit, byte_data is valid.
REQ-011 The block SHALL have port byte_ready, input, 1 bit, downstream accepts byte when high with byte_valid.
REQ-012 The block SHALL have port byte_last, output, 1 bit, high with the final byte of the file.
REQ-013 The block SHALL have port done, output, 1 bit, high from the cycle after the last byte transfers until the next start.

Function
REQ-014 The block SHALL implement states IDLE, REQ, WAIT, DRAIN, DONE.
REQ-015 IDLE: start high moves to REQ; all other inputs ignored.
REQ-016 REQ: cs SHALL be high for exactly this one cycle; next state WAIT.
REQ-017 WAIT: on valid high, the block SHALL latch data_out into an 8*WORD_BYTES buffer, latch eof into a last-word flag, clear the byte index to 0, and go to DRAIN; without valid it SHALL remain in WAIT indefinitely.
REQ-018 valid arriving in any state other than WAIT SHALL be ignored.
REQ-019 DRAIN: byte_valid SHALL be high; byte_data SHALL be buffer byte [index], byte 0 being bits [8*WORD_BYTES-1 : 8*WORD_BYTES-8] (most significant first).
REQ-020 A transfer occurs when byte_valid and byte_ready are both high; byte_data SHALL be held stable while byte_ready is low.
REQ-021 On a transfer with index < WORD_BYTES-1, index SHALL increment by 1.
REQ-022 On a transfer with index = WORD_BYTES-1: if the last-word flag is set, go to DONE; otherwise go to REQ.
REQ-023 byte_last SHALL equal (DRAIN and last-word flag and index = WORD_BYTES-1).
REQ-024 DONE: done SHALL be high; start returns to REQ with buffer, index and flag cleared.
REQ-025 start outside IDLE and DONE SHALL be ignored.
REQ-026 Word-to-word throughput SHALL be WORD_BYTES + 2 cycles minimum with a single-cycle ROM response (REQ, WAIT, WORD_BYTES DRAIN cycles).

Reset
REQ-027 rst SHALL asynchronously force state IDLE, cs 0, byte_valid 0, byte_last 0, done 0, byte_data 0, buffer 0, index 0, last-word flag 0.
REQ-028 rst asserted mid-word SHALL discard the buffered word; no byte is emitted until a new start.

Configuration
REQ-029 With macro WORD_UNPACKER_BYTE_COUNT_EN defined, the block SHALL add output byte_count, 32 bits, incremented on every transfer, cleared by rst and by an accepted start, and wrapping from 0xFFFFFFFF to 0.
REQ-030 Without WORD_UNPACKER_BYTE_COUNT_EN the byte_count port and counter SHALL not exist; all other behaviour is identical.

Verification
REQ-031 Reset then start, ROM returns 0x0011223344556677 with eof=1, byte_ready=1 -> bytes 00,11,...,77 on 8 consecutive cycles, byte_last only on 77, done high next cycle.
REQ-032 Two-word file (0x0102030405060708, then 0x1112131415161718 with eof) -> 16 bytes in order, exactly 2 cs pulses, byte_last on 18.
REQ-033 byte_ready toggled 0/1 every cycle during DRAIN -> byte_data stable while not ready, no byte dropped or duplicated.
REQ-034 rst asserted at index 3 of the first word -> all outputs zero immediately; state IDLE; a later start re-requests from the first ROM word.
REQ-035 Spurious valid during DRAIN, and start pulsed during WAIT -> both ignored, byte stream unchanged.
REQ-036 With WORD_UNPACKER_BYTE_COUNT_EN, two-word file -> byte_count reads 16 at done, 0 after the next start.
